// File: rtl/cteq_cal_pkg.sv
// rtl/cteq_cal_pkg.sv - shared types and majority-vote helper for the CTLE fz calibration
package cteq_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_SETTLE,
    ST_ACC,
    ST_DECIDE,
    ST_TRACK,
    ST_DONE
  } cal_state_t;

  typedef struct packed {
    logic dec_down;
    logic dec_up;
    logic dec_hold;
  } dec_t;

  localparam int AVG_N_DEF      = 16;
  localparam int SETTLE_CYC_DEF = 64;
  localparam int ONES_W         = $clog2(AVG_N_DEF) + 1;
  localparam int SET_W          = $clog2(SETTLE_CYC_DEF + 1);

  // A tie (exactly half ones) is a hold, never a step.
  function automatic dec_t majority(input int unsigned ones, input int unsigned avg_n);
    dec_t d;
    d.dec_down = (2 * ones) > avg_n;
    d.dec_up   = (2 * ones) < avg_n;
    d.dec_hold = (2 * ones) == avg_n;
    return d;
  endfunction

endpackage

// File: rtl/cteq_cal_acc.sv
// rtl/cteq_cal_acc.sv - comparator sample window: counts AVG_N samples and the ones among them
module cteq_cal_acc
  import cteq_cal_pkg::*;
#(
  parameter int AVG_N   = AVG_N_DEF,
  parameter int CNT1_W  = $clog2(AVG_N) + 1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              clr,
  input  logic              en,
  input  logic              smp,
  output logic [CNT1_W-1:0] ones,
  output logic              acc_done
);

  localparam int CNT_W = $clog2(AVG_N);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT1_W-1:0] ones_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q  <= '0;
      ones_q <= '0;
    end else if (clr) begin
      cnt_q  <= '0;
      ones_q <= '0;
    end else if (en) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      ones_q <= ones_q + CNT1_W'(smp);
    end
  end

  // Asserted while the last sample is taken, so ones is complete on the next cycle.
  assign acc_done = en && (cnt_q == CNT_W'(AVG_N - 1));
  assign ones     = ones_q;

endmodule

// File: rtl/cteq_fz_cal.sv
// rtl/cteq_fz_cal.sv - SAR search plus optional +/-1 tracking of the CTLE fz DAC code
module cteq_fz_cal
  import cteq_cal_pkg::*;
#(
  parameter int                CODE_W     = 6,
  parameter int                SETTLE_CYC = 64,
  parameter int                AVG_N      = 16,
  parameter logic [CODE_W-1:0] CODE_INIT  = CODE_W'(32)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              cal_start,
  input  logic              track_en,
  input  logic              cmp_in,
  output logic [CODE_W-1:0] fz_code,
  output logic              cal_busy,
  output logic              cal_done
);

  localparam int CNT1_W   = $clog2(AVG_N) + 1;
  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
  localparam int K_W      = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  cal_state_t          state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [K_W-1:0]      k_q, k_d;
  logic                sar_q, sar_d;
  logic [SETTLE_W-1:0] set_cnt_q, set_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [CNT1_W-1:0]   ones;
  logic                acc_done;
  logic [CODE_W-1:0]   kbit;
  dec_t                dec;

  cteq_cal_acc #(
    .AVG_N  (AVG_N),
    .CNT1_W (CNT1_W)
  ) u_acc (
    .clk      (clk),
    .rstb     (rstb),
    .clr      (state_q != ST_ACC),
    .en       (state_q == ST_ACC),
    .smp      (cmp_in),
    .ones     (ones),
    .acc_done (acc_done)
  );

  assign kbit = CODE_W'(1) << k_q;
  assign dec  = majority(int'(ones), AVG_N);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    k_d       = k_q;
    sar_d     = sar_q;
    set_cnt_d = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cal_start) begin
          state_d = ST_SET;
          k_d     = K_W'(CODE_W - 1);
          sar_d   = 1'b1;
        end
      end
      ST_SET: begin
        // The first trial discards whatever code was left from a previous run.
        if (k_q == K_W'(CODE_W - 1)) code_d = kbit;
        else                         code_d = code_q | kbit;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (set_cnt_q == SETTLE_W'(SETTLE_CYC - 1)) state_d = ST_ACC;
        else                                        set_cnt_d = set_cnt_q + SETTLE_W'(1);
      end
      ST_ACC: begin
        if (acc_done) state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (sar_q) begin
          if (dec.dec_down) code_d = code_q & ~kbit;
          if (k_q != '0) begin
            k_d     = k_q - K_W'(1);
            state_d = ST_SET;
          end else if (track_en) begin
            state_d = ST_TRACK;
            sar_d   = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          if (dec.dec_hold)                            code_d = code_q;
          else if (dec.dec_down && code_q != '0)       code_d = code_q - CODE_W'(1);
          else if (dec.dec_up && code_q != {CODE_W{1'b1}}) code_d = code_q + CODE_W'(1);
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (!track_en) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
          sar_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    // While tracking the code stays valid through SETTLE/ACC/DECIDE as well.
    done_d = (state_d == ST_DONE) || (state_d == ST_TRACK) ||
             (!sar_d && (state_d == ST_SETTLE || state_d == ST_ACC || state_d == ST_DECIDE));
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      code_q    <= CODE_INIT;
      k_q       <= K_W'(CODE_W - 1);
      sar_q     <= 1'b0;
      set_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      k_q       <= k_d;
      sar_q     <= sar_d;
      set_cnt_q <= set_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign fz_code  = code_q;
  assign cal_busy = busy_q;
  assign cal_done = done_q;

endmodule

// File: tb/tb_cteq_fz_cal.sv
// tb/tb_cteq_fz_cal.sv - self-checking bench for cteq_fz_cal with small settle/average windows
module tb_cteq_fz_cal;

  localparam int CODE_W     = 6;
  localparam int SETTLE_CYC = 4;
  localparam int AVG_N      = 4;
  localparam int PER        = SETTLE_CYC + AVG_N + 2;
  localparam int ACC_OFS    = 1 + SETTLE_CYC;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              cal_start = 1'b0;
  logic              track_en = 1'b0;
  logic              cmp_in = 1'b0;
  logic [CODE_W-1:0] fz_code;
  logic              cal_busy;
  logic              cal_done;

  always #5 clk = ~clk;

  cteq_fz_cal #(
    .CODE_W     (CODE_W),
    .SETTLE_CYC (SETTLE_CYC),
    .AVG_N      (AVG_N),
    .CODE_INIT  (6'd32)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .cal_start (cal_start),
    .track_en  (track_en),
    .cmp_in    (cmp_in),
    .fz_code   (fz_code),
    .cal_busy  (cal_busy),
    .cal_done  (cal_done)
  );

  typedef struct {
    string name;
    int    policy;
    int    thr;
    int    exp_code;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   failures = 0;
  logic rnd_smp[0:99];
  int   seq[6];
  int   exp_seq[6];
  int   done_cyc;
  bit   stable;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // 0: stuck 0, 1: stuck 1, 2: alternating, 3: cmp = code > thr, 4: random table
  function automatic logic pol(input int policy, input int thr, input int c, input logic [CODE_W-1:0] code);
    case (policy)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return c[0];
      3:       return int'(code) > thr;
      default: return rnd_smp[c];
    endcase
  endfunction

  // Bit b is tried at cycles b*PER+1 .. b*PER+PER-1; its vote uses cycles b*PER+ACC_OFS .. +AVG_N-1.
  function automatic int model_random();
    int code = 0;
    for (int b = 0; b < CODE_W; b++) begin
      int trial = code | (1 << (CODE_W - 1 - b));
      int n1 = 0;
      for (int j = 0; j < AVG_N; j++) n1 += int'(rnd_smp[b * PER + ACC_OFS + j]);
      exp_seq[b] = trial;
      if (2 * n1 > AVG_N) trial = trial & ~(1 << (CODE_W - 1 - b));
      code = trial;
    end
    return code;
  endfunction

  // Starts a search and returns at the negedge of the first cycle with cal_done high.
  task automatic run_sar(input int policy, input int thr, input int extra_start);
    done_cyc = -1;
    stable = 1'b1;
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (c / PER < CODE_W && c % PER >= 1) begin
        if (c % PER == 1) seq[c / PER] = int'(fz_code);
        else if (int'(fz_code) != seq[c / PER]) stable = 1'b0;
      end
      if (cal_done) begin
        done_cyc = c;
        break;
      end
      cal_start = (c == extra_start);
      cmp_in = pol(policy, thr, c, fz_code);
      @(negedge clk);
    end
    cal_start = 1'b0;
  endtask

  initial begin
    bit done_ok;
    int fin;
    int w;
    int exp_c;
    int conv37[6];

    vecs[0] = '{"stuck1",   1, 0, 0};
    vecs[1] = '{"stuck0",   0, 0, 63};
    vecs[2] = '{"tie_alt",  2, 0, 63};
    vecs[3] = '{"thr37",    3, 37, 37};
    vecs[4] = '{"thr0",     3, 0, 0};
    vecs[5] = '{"thr63",    3, 63, 63};
    vecs[6] = '{"thr20",    3, 20, 20};
    conv37[0] = 32; conv37[1] = 48; conv37[2] = 40;
    conv37[3] = 36; conv37[4] = 38; conv37[5] = 37;

    repeat (2) @(negedge clk);
    chk("reset_code", int'(fz_code), 32);
    chk("reset_busy", int'(cal_busy), 0);
    chk("reset_done", int'(cal_done), 0);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(cal_busy), 0);

    run_sar(3, 37, -1);
    for (int b = 0; b < CODE_W; b++) chk($sformatf("conv37_bit%0d", b), seq[b], conv37[b]);
    chk("conv37_done_cycle", done_cyc, 6 * PER);
    chk("conv37_final", int'(fz_code), 37);
    chk("conv37_stable", int'(stable), 1);
    chk("conv37_busy_low", int'(cal_busy), 0);

    for (int i = 0; i < 7; i++) begin
      run_sar(vecs[i].policy, vecs[i].thr, -1);
      chk({vecs[i].name, "_final"}, int'(fz_code), vecs[i].exp_code);
      chk({vecs[i].name, "_done_cycle"}, done_cyc, 6 * PER);
      chk({vecs[i].name, "_stable"}, int'(stable), 1);
    end

    run_sar(3, 37, 3);
    chk("busy_start_done_cycle", done_cyc, 6 * PER);
    chk("busy_start_final", int'(fz_code), 37);

    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 100; c++) rnd_smp[c] = 1'($urandom_range(0, 1));
      fin = model_random();
      run_sar(4, 0, -1);
      for (int b = 0; b < CODE_W; b++) chk($sformatf("rnd%0d_bit%0d", r, b), seq[b], exp_seq[b]);
      chk($sformatf("rnd%0d_final", r), int'(fz_code), fin);
      chk($sformatf("rnd%0d_done_cycle", r), done_cyc, 6 * PER);
    end

    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    cmp_in = 1'b0;
    repeat (3 * PER + ACC_OFS + 1) @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("midrst_code", int'(fz_code), 32);
    chk("midrst_busy", int'(cal_busy), 0);
    chk("midrst_done", int'(cal_done), 0);
    @(negedge clk);
    rstb = 1'b1;
    repeat (5) @(negedge clk);
    chk("postrst_busy", int'(cal_busy), 0);
    chk("postrst_done", int'(cal_done), 0);
    chk("postrst_code", int'(fz_code), 32);

    track_en = 1'b1;
    run_sar(3, 37, -1);
    chk("track_entry_cycle", done_cyc, 6 * PER);
    chk("track_entry_code", int'(fz_code), 37);
    cmp_in = 1'b1;
    done_ok = 1'b1;
    for (int c = 6 * PER; c <= 6 * PER + 40 * PER + 1; c++) begin
      if (!cal_done) done_ok = 1'b0;
      if ((c - 6 * PER) % PER == 1) begin
        exp_c = 37 - (c - 6 * PER) / PER;
        if (exp_c < 0) exp_c = 0;
        chk($sformatf("track_step_c%0d", c), int'(fz_code), exp_c);
      end
      if (c < 6 * PER + 40 * PER + 1) @(negedge clk);
    end
    track_en = 1'b0;
    w = 0;
    while (cal_busy && w < PER) begin
      @(negedge clk);
      w++;
      if (!cal_done) done_ok = 1'b0;
    end
    chk("track_exit_busy", int'(cal_busy), 0);
    chk("track_exit_done", int'(cal_done), 1);
    chk("track_done_never_low", int'(done_ok), 1);
    chk("track_exit_code", int'(fz_code), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
